// File: rtl/aes_fwd_sbox_iter.sv
// Iterative forward AES S-box: SubBytes(x) = A(x^254) over GF(2^8) mod 0x11B.
// One squarer and one multiplier are used per cycle; x^254 is built
// MSB-first from the exponent bits 1111_1110 over seven CALC cycles.
// Byte-serial with valid/ready handshakes on both sides.
module aes_fwd_sbox_iter #(
    parameter logic [7:0] AFFINE_C = 8'h63,
    parameter bit         OUT_REG  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // cnt value on the final CALC cycle (exponent LSB, square only)
    localparam logic [2:0] LAST_STEP = 3'd6;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] acc;
    logic [7:0] x_reg;
    logic [2:0] cnt;
    logic [7:0] out_q;
    logic [7:0] acc_sq;
    logic [7:0] acc_sq_mul;

    // Multiply by the polynomial x, reducing modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    // Horner-style GF(2^8) multiply, consuming b MSB first.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] bb;
        p  = 8'h00;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            p  = xtime(p) ^ (bb[7] ? a : 8'h00);
            bb = {bb[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_sq(input logic [7:0] a);
        return gf_mul(a, a);
    endfunction

    // b_i = a_i ^ a_(i+4) ^ a_(i+5) ^ a_(i+6) ^ a_(i+7) ^ c_i: the four extra
    // terms are the byte rotated left by 4, 3, 2 and 1 positions.
    function automatic logic [7:0] affine(input logic [7:0] a);
        return a
             ^ {a[6:0], a[7]}
             ^ {a[5:0], a[7:6]}
             ^ {a[4:0], a[7:5]}
             ^ {a[3:0], a[7:4]}
             ^ AFFINE_C;
    endfunction

    assign acc_sq     = gf_sq(acc);
    assign acc_sq_mul = gf_mul(acc_sq, x_reg);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush overrides any handshake.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch forms.
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid)         state_nxt = CALC;
                CALC:    if (cnt == LAST_STEP) state_nxt = DONE;
                DONE:    if (out_ready)        state_nxt = IDLE;
                default:                       state_nxt = IDLE;
            endcase
        end
    end

    // Datapath: operand capture, square-and-multiply steps, result register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every datapath register has a reset value so out_data is
        // defined (0) straight out of reset; none of these is a memory array.
        if (!rst_n) begin
            acc   <= 8'h00;
            x_reg <= 8'h00;
            cnt   <= 3'd0;
            out_q <= 8'h00;
        end else if (flush) begin
            cnt <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_reg <= in_data;
                        acc   <= in_data;
                        cnt   <= 3'd0;
                    end
                end
                CALC: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == LAST_STEP) begin
                        acc <= acc_sq;
                        if (OUT_REG) begin
                            out_q <= affine(acc_sq);
                        end
                    end else begin
                        acc <= acc_sq_mul;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake and status outputs decoded from the state.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        if (OUT_REG) begin
            out_data = out_q;
        end else begin
            out_data = (state == DONE) ? affine(acc) : 8'h00;
        end
    end

endmodule

// File: tb/tb_aes_fwd_sbox_iter.sv
// Self-checking bench for aes_fwd_sbox_iter. Accepted bytes push their
// expected S-box value into a scoreboard queue; a monitor pops and compares
// whenever the DUT completes an output transfer. A second instance with
// OUT_REG=0 runs in lockstep so the combinational output path is covered too.
`timescale 1ns/1ps
module tb_aes_fwd_sbox_iter;

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp;
        int         acc_cyc;
    } sb_item_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b1;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       busy;
    logic       in_ready_c;
    logic       out_valid_c;
    logic [7:0] out_data_c;
    logic       busy_c;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit seen_valid = 1'b0;

    sb_item_t   sb_q[$];
    logic [7:0] inv [256];

    // FIPS-197 forward S-box
    logic [7:0] sbox [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    aes_fwd_sbox_iter #(.AFFINE_C(8'h63), .OUT_REG(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    aes_fwd_sbox_iter #(.AFFINE_C(8'h63), .OUT_REG(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_c), .in_data(in_data),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c),
        .busy(busy_c)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Present a byte until accepted; record the expected result on acceptance.
    task automatic send(input logic [7:0] d, input logic [7:0] e, input bit keep, output int acc_cyc);
        bit ok;
        ok      = 1'b0;
        acc_cyc = -1;
        in_data  = d;
        in_valid = 1'b1;
        for (int k = 0; k < 64 && !ok; k++) begin
            @(negedge clk);
            if (in_ready && !flush) begin
                acc_cyc = cyc + 1;
                sb_q.push_back('{din: d, exp: e, acc_cyc: cyc + 1});
                ok = 1'b1;
            end
        end
        @(posedge clk); #1;
        if (!keep) in_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_out_valid();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 64 && !ok; k++) begin
            @(negedge clk);
            if (out_valid) ok = 1'b1;
        end
        if (!ok) check("out_valid_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: output latency, data, round trip, and no output without a pending byte.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sb_q.size() == 0) begin
                check("out_valid_without_input", {31'd0, out_valid}, 32'd0);
                seen_valid = 1'b0;
            end else begin
                if (out_valid && !seen_valid) begin
                    check("latency", cyc - sb_q[0].acc_cyc, 32'd7);
                    check("out_valid_comb_instance", {31'd0, out_valid_c}, 32'd1);
                    seen_valid = 1'b1;
                end
                if (!out_valid) seen_valid = 1'b0;
                if (out_valid && out_ready && !flush) begin
                    check("out_data", {24'd0, out_data}, {24'd0, sb_q[0].exp});
                    check("out_data_comb", {24'd0, out_data_c}, {24'd0, sb_q[0].exp});
                    check("round_trip", {24'd0, inv[out_data]}, {24'd0, sb_q[0].din});
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        int a0;
        int a_prev;
        logic [7:0] vec_in  [5];
        logic [7:0] vec_out [5];
        vec_in  = '{8'h00, 8'h01, 8'h53, 8'hFF, 8'h10};
        vec_out = '{8'h63, 8'h7C, 8'hED, 8'h16, 8'hCA};
        for (int i = 0; i < 256; i++) inv[sbox[i]] = i[7:0];

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_out_data",  {24'd0, out_data},  32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Known vectors with out_ready held high
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(vec_in[i], vec_out[i], 1'b0, a0);
        repeat (12) @(posedge clk);
        #1;

        // Reset asserted mid-CALC discards the byte
        send(8'h53, 8'hED, 1'b0, a0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        check("midrst_busy",      {31'd0, busy},      32'd0);
        check("midrst_in_ready",  {31'd0, in_ready},  32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;

        // Backpressure: result held stable for 20 cycles
        out_ready = 1'b0;
        send(8'h53, 8'hED, 1'b0, a0);
        wait_out_valid();
        for (int k = 0; k < 20; k++) begin
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_out_data",  {24'd0, out_data},  32'hED);
            check("bp_in_ready",  {31'd0, in_ready},  32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_after_in_ready", {31'd0, in_ready}, 32'd1);
        check("bp_after_busy",     {31'd0, busy},     32'd0);
        check("bp_queue_drained",  sb_q.size(),       32'd0);
        @(posedge clk); #1;

        // Flush during CALC at cnt=3
        send(8'h77, sbox[8'h77], 1'b0, a0);
        repeat (3) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        sb_q.delete();
        check("flush_calc_busy",      {31'd0, busy},      32'd0);
        check("flush_calc_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_calc_in_ready",  {31'd0, in_ready},  32'd1);
        send(8'h01, 8'h7C, 1'b0, a0);
        repeat (10) @(posedge clk);
        #1;

        // Flush together with out_ready in DONE drops the result
        out_ready = 1'b0;
        send(8'hA5, sbox[8'hA5], 1'b0, a0);
        wait_out_valid();
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        sb_q.delete();
        check("flush_done_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_done_busy",      {31'd0, busy},      32'd0);
        repeat (3) @(posedge clk);
        #1;

        // Byte presented with flush high is not accepted
        flush    = 1'b1;
        in_data  = 8'h3C;
        in_valid = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_blocks_accept", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;

        // Exhaustive back-to-back sweep; initiation interval of 9 cycles
        a_prev = 0;
        for (int i = 0; i < 256; i++) begin
            send(i[7:0], sbox[i], 1'b1, a0);
            if (i > 0) check("initiation_interval", a0 - a_prev, 32'd9);
            a_prev = a0;
        end
        in_valid = 1'b0;

        // Drain
        for (int k = 0; k < 40 && sb_q.size() != 0; k++) @(posedge clk);
        #1;
        check("final_queue_empty", sb_q.size(), 32'd0);
        repeat (3) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
